freq_code_detector: RTL and testbench

Receive-side decoder for the ring-oscillator frequency-select path. It watches the carry pulse produced by the frequency selector: a 9-bit counter that reloads `{SW,6'b0}` on carry, so the pulse spacing is P = 512 − 64·SW `RO_Clk` cycles. It measures the spacing between pulses and recovers the 3-bit select code. After a run of identical valid periods it reports the code as locked. It sits on the `RO_Clk` domain next to the waveform generator and is used for self-check and status display.

---
 rtl/freq_code_detector_if.sv | 23 ++
 rtl/freq_code_detector.sv | 157 +++++++++++++++
 tb/tb_freq_code_detector.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/freq_code_detector_if.sv
// Handshake-free status bundle between the frequency-code detector and its user.
// Latency: n/a (wires only); the detector registers every output it drives here.
// Backpressure: none; pulse_in is sampled every RO_Clk cycle.
interface freq_code_detector_if;
    logic       clr;        // synchronous clear, same effect as reset
    logic       pulse_in;   // carry pulse from the frequency selector
    logic [2:0] sw_out;     // decoded select code, valid while locked
    logic       locked;     // code stable over LOCK_N periods
    logic       err;        // one-cycle pulse on invalid period or timeout
    logic [9:0] period;     // last measured pulse spacing in cycles

    // Side that drives the pulse/clear and watches the status.
    modport master (
        output clr, pulse_in,
        input  sw_out, locked, err, period
    );

    // Detector side.
    modport slave (
        input  clr, pulse_in,
        output sw_out, locked, err, period
    );
endinterface

// File: rtl/freq_code_detector.sv
// Recovers the 3-bit select code from the carry-pulse spacing (P = 512 - 64*SW) and reports lock.
// Latency: outputs update at the edge that samples a pulse; lock after LOCK_N equal valid periods.
// Backpressure: none; every high pulse_in sample is a pulse. FREQ_DET_TOL_EN enables +/-1 cycle jitter tolerance.
module freq_code_detector #(
    parameter int LOCK_N  = 2,      // 1..7
    parameter int TIMEOUT = 1023    // 520..1023
) (
    input  logic                  RO_Clk,
    input  logic                  rst,
    freq_code_detector_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MEAS   = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    localparam logic [2:0] LP_LOCK  = 3'(LOCK_N);
    localparam logic [9:0] LP_TO    = 10'(TIMEOUT);
    localparam logic [9:0] LP_TO_M1 = 10'(TIMEOUT - 1);

    state_t     r_state;
    logic [9:0] r_cnt;
    logic [2:0] r_cand;
    logic [2:0] r_mcnt;
    logic [2:0] r_sw_out;
    logic       r_locked;
    logic       r_err;
    logic [9:0] r_period;

    logic [9:0] w_p;        // measured period, only meaningful on a pulse cycle
    logic [9:0] w_q;        // value the code is extracted from
    logic       w_valid;
    logic [2:0] w_code;
    logic       w_match;
    logic [2:0] w_mcnt_nxt;
    logic       w_timeout;

    assign w_p = r_cnt + 10'd1;

`ifdef FREQ_DET_TOL_EN
    // Shift by one so P-1, P, P+1 land on residues 0..2 of the same 64-cycle bin.
    // 63 <= P <= 513 is the same as 64 <= P+1 <= 514; P=1023 wraps to 0 and fails the range.
    assign w_q     = w_p + 10'd1;
    assign w_valid = (w_q[5:0] <= 6'd2) && (w_q >= 10'd64) && (w_q <= 10'd514);
`else
    assign w_q     = w_p;
    assign w_valid = (w_q[5:0] == 6'd0) && (w_q >= 10'd64) && (w_q <= 10'd512);
`endif

    // code = 8 - (q >> 6) mod 8, which is the 3-bit negation of q[8:6]
    assign w_code     = 3'd0 - w_q[8:6];
    assign w_match    = (w_code == r_cand) && (r_mcnt != 3'd0);
    assign w_mcnt_nxt = w_match ? (r_mcnt + 3'd1) : 3'd1;
    // Fires on the edge where cnt would reach TIMEOUT; a pulse on that edge wins.
    assign w_timeout  = !bus.pulse_in && (r_cnt == LP_TO_M1);

    // Period counter plus the lock FSM, all outputs registered.
    always_ff @(posedge RO_Clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 10'd0;
            r_cand   <= 3'd0;
            r_mcnt   <= 3'd0;
            r_sw_out <= 3'd0;
            r_locked <= 1'b0;
            r_err    <= 1'b0;
            r_period <= 10'd0;
        end else if (bus.clr) begin
            r_state  <= S_IDLE;
            r_cnt    <= 10'd0;
            r_cand   <= 3'd0;
            r_mcnt   <= 3'd0;
            r_sw_out <= 3'd0;
            r_locked <= 1'b0;
            r_err    <= 1'b0;
            r_period <= 10'd0;
        end else begin
            r_err <= 1'b0;

            if (bus.pulse_in) begin
                r_cnt <= 10'd0;
            end else if (r_cnt != LP_TO) begin
                r_cnt <= r_cnt + 10'd1;
            end

            case (r_state)
                S_IDLE: begin
                    // First pulse only opens the measurement window.
                    if (bus.pulse_in) begin
                        r_state <= S_MEAS;
                        r_mcnt  <= 3'd0;
                    end
                end

                S_MEAS: begin
                    if (bus.pulse_in) begin
                        r_period <= w_p;
                        if (w_valid) begin
                            r_cand <= w_code;
                            r_mcnt <= w_mcnt_nxt;
                            if (w_mcnt_nxt >= LP_LOCK) begin
                                r_sw_out <= w_code;
                                r_locked <= 1'b1;
                                r_state  <= S_LOCKED;
                            end
                        end else begin
                            r_err  <= 1'b1;
                            r_mcnt <= 3'd0;
                        end
                    end else if (w_timeout) begin
                        r_err    <= 1'b1;
                        r_locked <= 1'b0;
                        r_mcnt   <= 3'd0;
                        r_state  <= S_IDLE;
                    end
                end

                S_LOCKED: begin
                    if (bus.pulse_in) begin
                        r_period <= w_p;
                        if (w_valid) begin
                            // A new valid code starts a fresh match run; sw_out keeps the old code.
                            if (w_code != r_cand) begin
                                r_locked <= 1'b0;
                                r_cand   <= w_code;
                                r_mcnt   <= 3'd1;
                                r_state  <= S_MEAS;
                            end
                        end else begin
                            r_err    <= 1'b1;
                            r_locked <= 1'b0;
                            r_mcnt   <= 3'd0;
                            r_state  <= S_MEAS;
                        end
                    end else if (w_timeout) begin
                        r_err    <= 1'b1;
                        r_locked <= 1'b0;
                        r_mcnt   <= 3'd0;
                        r_state  <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.sw_out = r_sw_out;
    assign bus.locked = r_locked;
    assign bus.err    = r_err;
    assign bus.period = r_period;

endmodule

// File: tb/tb_freq_code_detector.sv
// Directed bench for freq_code_detector: lock, relock, invalid period, timeout, clear, async reset.
// Latency: checks sampled on the falling edge after the rising edge that took the pulse.
// Backpressure: none; pulses are driven on falling edges.
module tb_freq_code_detector;

`ifdef FREQ_DET_TOL_EN
    localparam bit TOL = 1'b1;
`else
    localparam bit TOL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;
    int   gap_err;

    freq_code_detector_if bus();

    freq_code_detector #(
        .LOCK_N  (2),
        .TIMEOUT (1023)
    ) dut (
        .RO_Clk (clk),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input int sw, input int lk, input int er, input int per);
        chk({tag, ".sw_out"}, 32'(bus.sw_out), 32'(sw));
        chk({tag, ".locked"}, 32'(bus.locked), 32'(lk));
        chk({tag, ".err"},    32'(bus.err),    32'(er));
        chk({tag, ".period"}, 32'(bus.period), 32'(per));
    endtask

    // Called on the falling edge right after the previous pulse was sampled;
    // the new pulse is sampled p rising edges after that one, so the spacing is p.
    task automatic send_pulse(input int p);
        gap_err = 0;
        bus.pulse_in = 1'b0;
        for (int i = 0; i < p - 1; i++) begin
            @(negedge clk);
            if (bus.err) gap_err++;
        end
        bus.pulse_in = 1'b1;
        @(negedge clk);
        bus.pulse_in = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        bus.clr      = 1'b0;
        bus.pulse_in = 1'b0;
        repeat (3) @(negedge clk);
        chk4("reset", 0, 0, 0, 0);
        rst = 1'b0;

        // SW=3: 320-cycle spacing, lock after the third pulse
        send_pulse(5);
        chk4("first", 0, 0, 0, 0);
        send_pulse(320);
        chk4("p320a", 0, 0, 0, 320);
        send_pulse(320);
        chk4("lock3", 3, 1, 0, 320);
        chk("lock3.gap_err", 32'(gap_err), 0);

        // switch to 128: drop with old code held, relock on 6
        send_pulse(128);
        chk4("drop128", 3, 0, 0, 128);
        send_pulse(128);
        chk4("lock6", 6, 1, 0, 128);

        // move to code 0 (P=512)
        send_pulse(512);
        chk4("drop512", 6, 0, 0, 512);
        send_pulse(512);
        chk4("lock0", 0, 1, 0, 512);

        // invalid 300: one-cycle err, relock after two more 512 periods
        send_pulse(300);
        chk4("bad300", 0, 0, 1, 300);
        send_pulse(512);
        chk4("after300", 0, 0, 0, 512);
        chk("err_width.gap_err", 32'(gap_err), 0);
        send_pulse(512);
        chk4("relock0", 0, 1, 0, 512);

        // period 321: accepted as code 3 only with jitter tolerance
        send_pulse(321);
        chk4("p321", 0, 0, TOL ? 0 : 1, 321);
        send_pulse(320);
        chk4("p320c", TOL ? 3 : 0, TOL ? 1 : 0, 0, 320);
        send_pulse(320);
        chk4("lock3b", 3, 1, 0, 320);

        // pulses stop: err when cnt reaches 1023
        gap_err = 0;
        repeat (1022) begin
            @(negedge clk);
            if (bus.err) gap_err++;
        end
        chk("pre_to.gap_err", 32'(gap_err), 0);
        chk("pre_to.locked", 32'(bus.locked), 1);
        @(negedge clk);
        chk4("timeout", 3, 0, 1, 320);
        @(negedge clk);
        chk("timeout_end.err", 32'(bus.err), 0);

        // back in IDLE: next pulse does not update period
        send_pulse(200);
        chk4("idle_pulse", 3, 0, 0, 320);
        send_pulse(256);
        chk4("p256a", 3, 0, 0, 256);
        send_pulse(256);
        chk4("lock4", 4, 1, 0, 256);

        // clr together with a pulse while locked
        bus.pulse_in = 1'b0;
        repeat (255) @(negedge clk);
        bus.pulse_in = 1'b1;
        bus.clr      = 1'b1;
        @(negedge clk);
        bus.pulse_in = 1'b0;
        bus.clr      = 1'b0;
        chk4("clr", 0, 0, 0, 0);
        send_pulse(256);
        chk4("clr_p1", 0, 0, 0, 0);
        send_pulse(256);
        chk4("clr_p2", 0, 0, 0, 256);
        send_pulse(256);
        chk4("clr_p3", 4, 1, 0, 256);

        // asynchronous reset mid-measurement
        repeat (100) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk4("arst", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        // pulse held high for 4 cycles: err on every cycle after the first
        bus.pulse_in = 1'b1;
        @(negedge clk);
        chk("held1.err", 32'(bus.err), 0);
        @(negedge clk);
        chk("held2.err", 32'(bus.err), 1);
        @(negedge clk);
        chk("held3.err", 32'(bus.err), 1);
        @(negedge clk);
        chk("held4.err", 32'(bus.err), 1);
        bus.pulse_in = 1'b0;
        @(negedge clk);
        chk4("held_end", 0, 0, 0, 1);

        // one cycle already elapsed since the last pulse, so 1022 more gives P=1023:
        // the pulse lands on the timeout edge and wins (measured, stays in MEAS)
        send_pulse(1022);
        chk4("edge_to", 0, 0, 1, 1023);
        send_pulse(512);
        chk4("after_edge", 0, 0, 0, 512);
        send_pulse(512);
        chk4("lock0b", 0, 1, 0, 512);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
